// File: rtl/eq_pkg.sv
// Shared defaults for the FFT band equaliser: parameter defaults, register
// map bases and the reset edge table.
package eq_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int NUM_BANDS_DEF = 12;
    localparam int BIN_W_DEF     = 14;
    localparam int GAIN_W_DEF    = 5;
    localparam int UNITY_DEF     = 13;
    localparam int MAX_BANDS     = 16;

    localparam logic [5:0] ADDR_GAIN_BASE = 6'd0;
    localparam logic [5:0] ADDR_EDGE_BASE = 6'd32;

    // Exclusive upper bin of each band; entries past the twelfth repeat the last edge.
    localparam int DEF_EDGE [MAX_BANDS] = '{10, 20, 37, 64, 100, 151, 325, 696,
                                            1208, 2043, 3158, 4096, 4096, 4096, 4096, 4096};

endpackage

// File: rtl/fft_band_eq_if.sv
// Stream-in, stream-out and register-bus signals of the band equaliser.
// A stream beat transfers on a clock edge where valid && ready; the source
// holds data and qualifiers stable while valid is high and ready is low.
interface fft_band_eq_if
    import eq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic signed [DATA_W-1:0] in_real;
    logic signed [DATA_W-1:0] in_imag;
    logic                     in_valid;
    logic                     in_sop;
    logic                     in_eop;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_real;
    logic signed [DATA_W-1:0] out_imag;
    logic                     out_valid;
    logic                     out_sop;
    logic                     out_eop;
    logic                     out_ready;
    logic [5:0]               address;
    logic [15:0]              writedata;
    logic [15:0]              readdata;
    logic                     chipselect;
    logic                     write;
    logic                     read;

    modport master (
        output in_real, in_imag, in_valid, in_sop, in_eop, out_ready,
        output address, writedata, chipselect, write, read,
        input  in_ready, out_real, out_imag, out_valid, out_sop, out_eop, readdata
    );

    modport slave (
        input  in_real, in_imag, in_valid, in_sop, in_eop, out_ready,
        input  address, writedata, chipselect, write, read,
        output in_ready, out_real, out_imag, out_valid, out_sop, out_eop, readdata
    );

endinterface

// File: rtl/eq_shift_sat.sv
// Scales one signed sample by 2^(gain-UNITY): arithmetic right shift for cuts,
// saturating left shift for boosts, zero once the cut clears every bit.
module eq_shift_sat
    import eq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int UNITY  = UNITY_DEF
) (
    input  logic [GAIN_W-1:0]        gain,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);

    // Headroom wide enough for the largest possible boost.
    localparam int WW = DATA_W + (1 << GAIN_W);

    int                   sh;
    logic signed [WW-1:0] wide;
    logic signed [WW-1:0] max_v;
    logic signed [WW-1:0] min_v;

    always_comb begin
        sh    = UNITY - int'(gain);
        max_v = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        min_v = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        wide  = {{(WW-DATA_W){x[DATA_W-1]}}, x};
        y     = x;
        if (sh >= DATA_W - 1) begin
            y = '0;
        end else if (sh > 0) begin
            y = x >>> sh;
        end else if (sh < 0) begin
            wide = wide <<< (-sh);
            if (wide > max_v)      y = max_v[DATA_W-1:0];
            else if (wide < min_v) y = min_v[DATA_W-1:0];
            else                   y = wide[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fft_band_eq.sv
// Per-band gain equaliser for FFT bin streams: stage 1 counts bins and picks
// the band gain, stage 2 shifts/saturates; settings switch only at frame start.
module fft_band_eq
    import eq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_BANDS = NUM_BANDS_DEF,
    parameter int BIN_W     = BIN_W_DEF,
    parameter int GAIN_W    = GAIN_W_DEF,
    parameter int UNITY     = UNITY_DEF
) (
    input logic         clk,
    input logic         reset_n,
    fft_band_eq_if.slave bus
);

    localparam int               BAND_W  = $clog2(NUM_BANDS);
    localparam logic [BIN_W-1:0] BIN_MAX = '1;

    logic [GAIN_W-1:0]        gain_sh  [NUM_BANDS];
    logic [GAIN_W-1:0]        gain_act [NUM_BANDS];
    logic [BIN_W-1:0]         edge_sh  [NUM_BANDS];
    logic [BIN_W-1:0]         edge_act [NUM_BANDS];
    logic [BIN_W-1:0]         bin_cnt;
    logic [BIN_W-1:0]         bin_cur;
    logic [BAND_W-1:0]        band;
    logic [GAIN_W-1:0]        gain_cur;
    logic [15:0]              rd_val;
    logic                     s1_full;
    logic signed [DATA_W-1:0] s1_real;
    logic signed [DATA_W-1:0] s1_imag;
    logic                     s1_sop;
    logic                     s1_eop;
    logic [GAIN_W-1:0]        s1_gain;
    logic signed [DATA_W-1:0] sc_real;
    logic signed [DATA_W-1:0] sc_imag;
    logic                     s2_free;
    logic                     s1_moves;
    logic                     in_fire;
    logic                     sop_fire;
    logic                     wr_en;
    logic                     rd_en;
    logic                     unused_bits;

    assign s2_free      = !bus.out_valid || bus.out_ready;
    assign s1_moves     = s1_full && s2_free;
    assign bus.in_ready = !s1_full || s1_moves;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign sop_fire     = in_fire && bus.in_sop;
    assign wr_en        = bus.chipselect && bus.write;
    assign rd_en        = bus.chipselect && bus.read && !bus.write;
    assign unused_bits  = &{1'b0, bus.writedata};

    // The sop beat already belongs to the new frame, so it sees the shadow set.
    always_comb begin
        bin_cur = bus.in_sop ? '0 : ((bin_cnt == BIN_MAX) ? BIN_MAX : bin_cnt + BIN_W'(1));
        band    = BAND_W'(NUM_BANDS - 1);
        for (int b = NUM_BANDS - 1; b >= 0; b--) begin
            if (bin_cur < (bus.in_sop ? edge_sh[b] : edge_act[b])) band = BAND_W'(b);
        end
        gain_cur = bus.in_sop ? gain_sh[band] : gain_act[band];
    end

    always_comb begin
        rd_val = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (bus.address == ADDR_GAIN_BASE + 6'(b)) rd_val = 16'(gain_sh[b]);
            if (bus.address == ADDR_EDGE_BASE + 6'(b)) rd_val = 16'(edge_sh[b]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain_sh[b]  <= GAIN_W'(UNITY);
                gain_act[b] <= GAIN_W'(UNITY);
                edge_sh[b]  <= BIN_W'(DEF_EDGE[b]);
                edge_act[b] <= BIN_W'(DEF_EDGE[b]);
            end
            bus.readdata <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    if (bus.address == ADDR_GAIN_BASE + 6'(b)) gain_sh[b] <= bus.writedata[GAIN_W-1:0];
                    if (bus.address == ADDR_EDGE_BASE + 6'(b)) edge_sh[b] <= bus.writedata[BIN_W-1:0];
                end
            end
            if (sop_fire) begin
                gain_act <= gain_sh;
                edge_act <= edge_sh;
            end
            if (rd_en) bus.readdata <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt       <= '0;
            s1_full       <= 1'b0;
            s1_real       <= '0;
            s1_imag       <= '0;
            s1_sop        <= 1'b0;
            s1_eop        <= 1'b0;
            s1_gain       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_real  <= '0;
            bus.out_imag  <= '0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
        end else begin
            if (in_fire) begin
                bin_cnt <= bin_cur;
                s1_full <= 1'b1;
                s1_real <= bus.in_real;
                s1_imag <= bus.in_imag;
                s1_sop  <= bus.in_sop;
                s1_eop  <= bus.in_eop;
                s1_gain <= gain_cur;
            end else if (s1_moves) begin
                s1_full <= 1'b0;
            end
            if (s1_moves) begin
                bus.out_valid <= 1'b1;
                bus.out_real  <= sc_real;
                bus.out_imag  <= sc_imag;
                bus.out_sop   <= s1_sop;
                bus.out_eop   <= s1_eop;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    eq_shift_sat #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .UNITY(UNITY)) u_sat_real (
        .gain (s1_gain),
        .x    (s1_real),
        .y    (sc_real)
    );

    eq_shift_sat #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .UNITY(UNITY)) u_sat_imag (
        .gain (s1_gain),
        .x    (s1_imag),
        .y    (sc_imag)
    );

endmodule

// File: tb/tb_fft_band_eq.sv
// Bench for fft_band_eq: directed frames plus randomized frames scored against
// an arithmetic reference of the band/gain rules.
module tb_fft_band_eq;
    import eq_pkg::*;

    localparam int DW = 16;
    localparam int NB = 12;
    localparam int BW = 14;
    localparam int GW = 5;
    localparam int UN = 13;
    localparam int W  = 2 * DW + 2;
    localparam int BIN_TOP = (1 << BW) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    fft_band_eq_if #(.DATA_W(DW)) bus ();

    fft_band_eq #(.DATA_W(DW), .NUM_BANDS(NB), .BIN_W(BW), .GAIN_W(GW), .UNITY(UN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int acc_q[$];
    bit lat_mode   = 1'b0;
    bit rdy_rand   = 1'b0;
    bit rdy_level  = 1'b1;
    int sop_in = 0, eop_in = 0, sop_out = 0, eop_out = 0;
    int last_rd = 0;

    // Reference model: shadow/active tables and the current bin position.
    int m_gain_sh [NB];
    int m_gain_act[NB];
    int m_edge_sh [NB];
    int m_edge_act[NB];
    int m_bin;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_gain_sh[i]  = UN;
            m_gain_act[i] = UN;
            m_edge_sh[i]  = DEF_EDGE[i] % (1 << BW);
            m_edge_act[i] = DEF_EDGE[i] % (1 << BW);
        end
        m_bin = 0;
    endfunction

    function automatic logic [DW-1:0] scale(int x, int g);
        real    r;
        longint v;
        if (UN - g >= DW - 1) return '0;
        r = $floor(x * (2.0 ** (g - UN)));
        v = longint'(r);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[DW-1:0];
    endfunction

    function automatic logic [W-1:0] model_beat(int re, int im, bit sop, bit eop);
        int band;
        int g;
        if (sop) begin
            m_gain_act = m_gain_sh;
            m_edge_act = m_edge_sh;
            m_bin = 0;
        end else if (m_bin < BIN_TOP) begin
            m_bin++;
        end
        band = 0;
        while (band < NB && !(m_bin < m_edge_act[band])) band++;
        if (band == NB) band = NB - 1;
        g = m_gain_act[band];
        return {scale(re, g), scale(im, g), sop, eop};
    endfunction

    function automatic int m_reg(int addr);
        if (addr < NB) return m_gain_sh[addr];
        if (addr >= 32 && addr < 32 + NB) return m_edge_sh[addr - 32];
        return 0;
    endfunction

    // ---------------- output monitor ----------------
    logic [W-1:0] held_val;
    bit           held = 1'b0;
    logic [W-1:0] e;
    int           a;

    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) check("out_stable", {bus.out_real, bus.out_imag, bus.out_sop, bus.out_eop}, held_val);
            held     = bus.out_valid && !bus.out_ready;
            held_val = {bus.out_real, bus.out_imag, bus.out_sop, bus.out_eop};
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: got 0x%0h expected none", held_val);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("beat", {bus.out_real, bus.out_imag, bus.out_sop, bus.out_eop}, e);
                    if (lat_mode) check("latency", cyc - a, 2);
                end
                if (bus.out_sop) sop_out++;
                if (bus.out_eop) eop_out++;
            end
        end
    end

    // ---------------- downstream ready ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int re, int im, bit sop, bit eop);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_real  = DW'(re);
        bus.in_imag  = DW'(im);
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL in_ready_timeout: got in_ready=0 for 200 cycles expected 1");
        end
        if (ok) begin
            exp_q.push_back(model_beat(re, im, sop, eop));
            acc_q.push_back(cyc);
            sop_in += int'(sop);
            eop_in += int'(eop);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic reg_write(int addr, int data);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 6'(addr);
        bus.writedata  = 16'(data);
        if (addr < NB) m_gain_sh[addr] = data % (1 << GW);
        if (addr >= 32 && addr < 32 + NB) m_edge_sh[addr - 32] = data % (1 << BW);
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic reg_read(int addr, string tag);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 6'(addr);
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        last_rd = m_reg(addr);
        @(negedge clk);
        check(tag, bus.readdata, last_rd);
        tick();
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 4000; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sop     = 1'b0;
        bus.in_eop     = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        exp_q.delete();
        acc_q.delete();
        model_reset();
        last_rd = 0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", {bus.out_real, bus.out_imag, bus.out_sop, bus.out_eop}, 0);
        check("rst_readdata", bus.readdata, 0);
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1);
        tick();
    endtask

    task automatic frame(int len, int re, int im);
        for (int i = 0; i < len; i++) send(re, im, i == 0, i == len - 1);
    endtask

    // ---------------- directed sequence ----------------
    int t0;
    int edge_v;

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_real    = '0;
        bus.in_imag    = '0;
        bus.in_sop     = 1'b0;
        bus.in_eop     = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        #1;
        do_reset();

        // Unity defaults pass data through with two-cycle latency at full rate.
        lat_mode = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(32'h1000, int'($urandom_range(0, 65535)) - 32768, i == 0, i == 7);
        check("throughput_cycles", cyc - t0, 8);
        wait_drain();
        lat_mode = 1'b0;

        reg_read(0, "rd_gain0_default");
        reg_read(32 + 11, "rd_edge11_default");
        reg_read(20, "rd_unmapped");
        reg_read(63, "rd_top_addr");

        // Band 0 cut by 3 steps.
        reg_write(0, 10);
        frame(11, 32'h0800, 32'h0800);
        wait_drain();

        // Band 1 boosted until it saturates both ways.
        reg_write(1, 18);
        for (int i = 0; i < 20; i++)
            send((i < 10) ? 32'h0800 : ((i % 2 == 0) ? 32'h0400 : -32'sh0400),
                 (i % 2 == 0) ? -32'sh0400 : 32'h0400, i == 0, i == 19);
        wait_drain();
        reg_read(1, "rd_gain1");

        // Write and read together: the write wins and readdata keeps its value.
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 6'd3;
        bus.writedata  = 16'd9;
        m_gain_sh[3]   = 9;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        @(negedge clk);
        check("wr_rd_priority", bus.readdata, last_rd);
        tick();
        reg_read(3, "rd_gain3");

        // Gain change mid-frame waits for the next sop.
        for (int i = 0; i < 16; i++) send(32'h1000, 32'h0200, i == 0, 1'b0);
        reg_write(2, 0);
        for (int i = 16; i < 40; i++) send(32'h1000, 32'h0200, 1'b0, i == 39);
        frame(40, 32'h1000, 32'h0200);
        wait_drain();

        // Edge rewrite and a restart on a second sop.
        reg_write(32, 5);
        reg_read(32, "rd_edge0");
        for (int i = 0; i < 8; i++) send(32'h0800, -32'sh0800, i == 0, 1'b0);
        for (int i = 0; i < 8; i++) send(32'h0800, -32'sh0800, i == 0, i == 7);
        wait_drain();

        // Random tables, random data, random backpressure across a full frame.
        for (int b = 0; b < NB; b++) reg_write(b, int'($urandom_range(0, 31)));
        edge_v = 0;
        for (int b = 0; b < NB; b++) begin
            edge_v += int'($urandom_range(1, 600));
            reg_write(32 + b, edge_v);
        end
        sop_in = 0; eop_in = 0; sop_out = 0; eop_out = 0;
        rdy_rand = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 i == 0, i == 4095);
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_drain();
        rdy_rand = 1'b0;
        check("sop_count", sop_out, sop_in);
        check("eop_count", eop_out, eop_in);

        // Bin counter must saturate instead of wrapping back to band 0.
        reg_write(0, 20);
        reg_write(32 + 10, BIN_TOP);
        reg_write(10, 13);
        reg_write(11, 5);
        for (int i = 0; i < BIN_TOP + 8; i++)
            send(int'($urandom_range(0, 65535)) - 32768, 32'h0100, i == 0, i == BIN_TOP + 7);
        wait_drain();

        // Reset in the middle of a stalled frame.
        reg_write(2, 7);
        rdy_level = 1'b0;
        tick();
        send(32'h1234, 32'h0042, 1'b1, 1'b0);
        send(32'h2345, 32'h0043, 1'b0, 1'b0);
        do_reset();
        rdy_level = 1'b1;
        reg_read(0, "rd_gain0_after_rst");
        reg_read(2, "rd_gain2_after_rst");
        frame(12, 32'h0300, -32'sh0300);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_band_eq.md
FFT_BAND_EQ -- requirements
Module: fft_band_eq

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 16, width of each real/imag sample.
- NUM_BANDS, 12, number of gain bands (2..16).
- BIN_W, 14, bin index width.
- GAIN_W, 5, gain code width.
- UNITY, 13, gain code giving 0 dB.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock for datapath and register bus.
- reset_n  in  1  asynchronous, active-low reset.
- in_real, in_imag  in  DATA_W  signed input bin.
- in_valid, in_sop, in_eop  in  1  input stream qualifiers.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_real, out_imag  out  DATA_W  scaled bin.
- out_valid, out_sop, out_eop  out  1  output qualifiers.
- out_ready  in  1  downstream accept.
- address  in  6  register select.
- writedata  in  16  write value.
- readdata  out  16  read value.
- chipselect, write, read  in  1  bus strobes.
REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous, active-low (reset_n).

Function
REQ-004 Register map: address 0..NUM_BANDS-1 = gain[b] (writedata[GAIN_W-1:0]); 32..32+NUM_BANDS-1 = edge[b] (writedata[BIN_W-1:0], exclusive upper bin of band b); other addresses: write ignored, read 0.
REQ-005 Writes update shadow registers; shadow SHALL copy into active registers on the cycle an in_sop beat is accepted, so a frame never sees mixed settings.
REQ-006 Read: readdata SHALL be registered and show the shadow value on the cycle after chipselect && read; write takes priority if both strobes are set.
REQ-007 Bin counter SHALL load 0 on an accepted sop beat, increment on each other accepted beat, and saturate at 2^BIN_W-1.
REQ-008 Band select: smallest b with bin < edge[b]; if none, band NUM_BANDS-1.
REQ-009 shift = UNITY - gain (signed); shift>0: arithmetic right shift; shift>=DATA_W-1: output 0; shift<0: left shift, saturating to +2^(DATA_W-1)-1 / -2^(DATA_W-1).
REQ-010 Pipeline SHALL be 2 stages (stage 1: bin count + band select; stage 2: shift/saturate); latency 2 cycles when out_ready held high.
REQ-011 sop, eop and valid SHALL travel with their data unchanged.
REQ-012 Backpressure: a stage SHALL hold when its successor is full and not draining; in_ready = !stage1_full || stage1_moves; no beat lost or duplicated; out_* stable while out_valid && !out_ready.
REQ-013 Full throughput: one beat per cycle while in_valid and out_ready are both high.
REQ-014 A second sop without an intervening eop SHALL restart the counter; no error state.

Reset
REQ-015 On reset_n low: all gains = UNITY; edge[b] = {10,20,37,64,100,151,325,696,1208,2043,3158,4096}[b], truncated to NUM_BANDS and to BIN_W bits; pipeline empty; out_valid, out_sop, out_eop = 0; out_real, out_imag, readdata = 0; bin counter 0.
REQ-016 Reset mid-frame SHALL drop in-flight beats; in_ready SHALL be 1 on the first cycle after release.

Structure
REQ-017 A shared package eq_pkg SHALL hold the parameter defaults, register address constants and the default edge table.
REQ-018 Shift/saturate logic SHALL be one sub-module, eq_shift_sat, instantiated once each for real and imag.

Verification
REQ-019 Reset defaults, 16-bit: feed 8 bins of 0x1000 with sop on the first -> out_* identical to inputs, latency 2.
REQ-020 gain[0]=10: bins 0..9 of 0x0800 -> 0x0100; bin 10 -> 0x0800.
REQ-021 gain[1]=18: 0x0400 -> 0x7FFF; -0x0400 -> 0x8000 (saturated).
REQ-022 gain[2]=0 written mid-frame -> no effect until the next sop; band 2 bins then output 0.
REQ-023 Random out_ready at 50% over a 4096-bin frame -> output sequence equals the reference model; sop/eop counts match.
REQ-024 Assert reset_n low mid-frame -> out_valid=0 and gains read back 13.
